// File: rtl/mips_cpu_avalon_pkg.sv
// Shared types for the MIPS CPU Avalon-MM arbiter: FSM encoding and the
// bundled request fields that get muxed from the granted master to the slave.
package mips_cpu_avalon_pkg;

    localparam int AV_ADDR_W = 32;
    localparam int AV_DATA_W = 32;
    localparam int AV_BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_M0 = 2'd1,
        BUSY_M1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [AV_ADDR_W-1:0] address;
        logic [AV_BE_W-1:0]   byteenable;
        logic                 read;
        logic                 write;
        logic [AV_DATA_W-1:0] writedata;
    } avalon_req_t;

    // A master is requesting whenever either command strobe is high.
    function automatic logic req_of(input avalon_req_t r);
        return r.read | r.write;
    endfunction

endpackage

// File: rtl/mips_cpu_avalon_arbiter_if.sv
// Avalon-MM bus bundle. The "master" modport is the side that issues
// commands; the "slave" modport is the side that answers with waitrequest
// and readdata.
// Handshake: a command (read or write high) is accepted at the posedge where
// waitrequest is low; while waitrequest is high the master holds address,
// byteenable, writedata and the command stable.
interface mips_cpu_avalon_arbiter_if;
    import mips_cpu_avalon_pkg::*;

    logic [AV_ADDR_W-1:0] address;
    logic [AV_BE_W-1:0]   byteenable;
    logic                 read;
    logic                 write;
    logic [AV_DATA_W-1:0] writedata;
    logic                 waitrequest;
    logic [AV_DATA_W-1:0] readdata;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata
    );

endinterface

// File: rtl/mips_cpu_avalon_arbiter.sv
// Two-master, one-slave Avalon-MM arbiter sharing the memory port between the
// instruction-fetch master (m0) and the data master (m1). The grant is held
// for a whole transfer, contention is resolved round-robin, every transfer is
// preceded by one idle cycle so the slave sees a fresh read/write edge, and a
// watchdog aborts a transfer whose slave never drops waitrequest.
module mips_cpu_avalon_arbiter
    import mips_cpu_avalon_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    mips_cpu_avalon_arbiter_if.slave    m0,
    mips_cpu_avalon_arbiter_if.slave    m1,
    mips_cpu_avalon_arbiter_if.master   s,
    output logic                        timeout,
    output arb_state_t                  o_dbg_state
);

    localparam int               WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    arb_state_t      r_state;
    logic            r_last_grant;
    logic [WD_W-1:0] r_wd_count;
    logic            r_timeout;

    arb_state_t      w_next_state;
    logic            w_next_last_grant;
    logic [WD_W-1:0] w_next_wd_count;
    logic            w_next_timeout;

    avalon_req_t     w_m0;
    avalon_req_t     w_m1;
    avalon_req_t     w_sel;
    logic            w_m0_req;
    logic            w_m1_req;
    logic            w_busy;
    logic            w_gnt_id;
    logic            w_gnt_req;

    assign w_m0 = '{address: m0.address, byteenable: m0.byteenable,
                    read: m0.read, write: m0.write, writedata: m0.writedata};
    assign w_m1 = '{address: m1.address, byteenable: m1.byteenable,
                    read: m1.read, write: m1.write, writedata: m1.writedata};

    assign w_m0_req  = req_of(w_m0);
    assign w_m1_req  = req_of(w_m1);
    assign w_busy    = (r_state == BUSY_M0) || (r_state == BUSY_M1);
    assign w_gnt_id  = (r_state == BUSY_M1);
    assign w_gnt_req = w_gnt_id ? w_m1_req : w_m0_req;

    assign timeout     = r_timeout;
    assign o_dbg_state = r_state;

    // State register, round-robin pointer, watchdog counter and sticky flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_wd_count   <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_last_grant;
            r_wd_count   <= w_next_wd_count;
            r_timeout    <= w_next_timeout;
        end
    end

    // Next-state logic: grant from IDLE, release on completion, abort or watchdog.
    always_comb begin
        w_next_state      = r_state;
        w_next_last_grant = r_last_grant;
        w_next_wd_count   = r_wd_count;
        w_next_timeout    = r_timeout;
        case (r_state)
            IDLE: begin
                w_next_wd_count = '0;
                if (w_m0_req && w_m1_req) begin
                    // The master that was not served last wins contention.
                    w_next_state = r_last_grant ? BUSY_M0 : BUSY_M1;
                end else if (w_m0_req) begin
                    w_next_state = BUSY_M0;
                end else if (w_m1_req) begin
                    w_next_state = BUSY_M1;
                end
            end
            BUSY_M0, BUSY_M1: begin
                if (!w_gnt_req) begin
                    // Master withdrew its command mid-transfer: release quietly.
                    w_next_state      = IDLE;
                    w_next_last_grant = w_gnt_id;
                    w_next_wd_count   = '0;
                end else if (!s.waitrequest) begin
                    // Command is forwarded, so s_read|s_write equals w_gnt_req here.
                    w_next_state      = IDLE;
                    w_next_last_grant = w_gnt_id;
                    w_next_wd_count   = '0;
                end else if (r_wd_count == WD_LAST) begin
                    // Slave is stuck: give the bus up and let the other master in.
                    w_next_state      = IDLE;
                    w_next_last_grant = w_gnt_id;
                    w_next_wd_count   = '0;
                    w_next_timeout    = 1'b1;
                end else begin
                    w_next_wd_count = r_wd_count + WD_W'(1);
                end
            end
            default: begin
                w_next_state    = IDLE;
                w_next_wd_count = '0;
            end
        endcase
    end

    // Output mux: forward the granted master to the slave, route waitrequest back.
    always_comb begin
        w_sel = w_gnt_id ? w_m1 : w_m0;

        s.address    = w_sel.address;
        s.byteenable = w_sel.byteenable;
        s.writedata  = w_sel.writedata;
        s.read       = w_busy & w_sel.read;
        s.write      = w_busy & w_sel.write;

        m0.waitrequest = (r_state == BUSY_M0) ? s.waitrequest : w_m0_req;
        m1.waitrequest = (r_state == BUSY_M1) ? s.waitrequest : w_m1_req;

        // Broadcast; only meaningful to the granted master on completion.
        m0.readdata = s.readdata;
        m1.readdata = s.readdata;
    end

endmodule

// File: tb/tb_mips_cpu_avalon_arbiter.sv
// Bench for mips_cpu_avalon_arbiter: two master drivers, a small memory slave
// with programmable wait states, and a completion scoreboard.
module tb_mips_cpu_avalon_arbiter;
    import mips_cpu_avalon_pkg::*;

    localparam int W = 34;  // {master id, is_read, readdata-or-zero}

    logic       clk;
    logic       reset;
    logic       timeout;
    arb_state_t dbg_state;

    mips_cpu_avalon_arbiter_if m0_bus ();
    mips_cpu_avalon_arbiter_if m1_bus ();
    mips_cpu_avalon_arbiter_if s_bus ();

    mips_cpu_avalon_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .m0          (m0_bus),
        .m1          (m1_bus),
        .s           (s_bus),
        .timeout     (timeout),
        .o_dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench did not finish");
    end

    // ---------------- slave model ----------------
    logic [31:0] sl_mem [0:15];
    logic [7:0]  sl_cnt;
    int          sl_wait_n = 0;
    logic        sl_hang   = 1'b0;

    assign s_bus.waitrequest = sl_hang | (int'(sl_cnt) < sl_wait_n);
    assign s_bus.readdata    = sl_mem[s_bus.address[5:2]];

    always @(posedge clk) begin
        if (reset) begin
            sl_cnt    <= 8'd0;
            sl_mem[1] <= 32'h1234_5678;
            sl_mem[4] <= 32'h0000_4444;
            sl_mem[8] <= 32'h1122_3344;
        end else if (s_bus.read | s_bus.write) begin
            if (!s_bus.waitrequest) begin
                sl_cnt <= 8'd0;
                if (s_bus.write) begin
                    for (int b = 0; b < 4; b++)
                        if (s_bus.byteenable[b])
                            sl_mem[s_bus.address[5:2]][8*b +: 8] <= s_bus.writedata[8*b +: 8];
                end
            end else begin
                sl_cnt <= sl_cnt + 8'd1;
            end
        end else begin
            sl_cnt <= 8'd0;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if ((m0_bus.read | m0_bus.write) && !m0_bus.waitrequest)
                score({1'b0, m0_bus.read, m0_bus.read ? m0_bus.readdata : 32'h0});
            if ((m1_bus.read | m1_bus.write) && !m1_bus.waitrequest)
                score({1'b1, m1_bus.read, m1_bus.read ? m1_bus.readdata : 32'h0});
        end
    end

    task automatic score(input logic [W-1:0] got);
        logic [W-1:0] exp;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_completion got=%0h exp=none", got);
        end else begin
            exp = exp_q.pop_front();
            check("completion", 64'(got), 64'(exp));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_m(input int id, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd);
        if (id == 0) begin
            m0_bus.read = rd; m0_bus.write = wr; m0_bus.address = addr;
            m0_bus.byteenable = be; m0_bus.writedata = wd;
        end else begin
            m1_bus.read = rd; m1_bus.write = wr; m1_bus.address = addr;
            m1_bus.byteenable = be; m1_bus.writedata = wd;
        end
    endtask

    function automatic logic wait_of(input int id);
        return (id == 0) ? m0_bus.waitrequest : m1_bus.waitrequest;
    endfunction

    // Issue one transfer and hold it until accepted (bounded).
    task automatic m_xfer(input int id, input logic rd, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd);
        bit done = 0;
        drive_m(id, rd, !rd, addr, be, wd);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!wait_of(id)) done = 1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL xfer_timeout m%0d got=stalled exp=accepted", id);
        end
        @(posedge clk);
        #1;
        drive_m(id, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic do_reset();
        drive_m(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive_m(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int cnt_hi;
    int cnt_wait_hi;
    int cnt_m0_wait;
    bit seen;

    initial begin
        reset = 1'b1;
        do_reset();
        @(negedge clk);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        check("rst_s_read", 64'(s_bus.read), 64'd0);
        check("rst_s_write", 64'(s_bus.write), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_m0_wait", 64'(m0_bus.waitrequest), 64'd0);
        check("rst_m1_wait", 64'(m1_bus.waitrequest), 64'd0);

        // Test 1: m1 read with 3 wait states.
        sl_wait_n = 3;
        @(posedge clk); #1;
        exp_q.push_back({1'b1, 1'b1, 32'h1234_5678});
        drive_m(1, 1'b1, 1'b0, 32'hBFC0_0004, 4'hF, 32'h0);
        cnt_hi = 0; cnt_wait_hi = 0; cnt_m0_wait = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (m0_bus.waitrequest) cnt_m0_wait++;
            if (s_bus.read) begin
                cnt_hi++;
                if (m1_bus.waitrequest) cnt_wait_hi++;
            end
            if (!m1_bus.waitrequest) seen = 1;
        end
        check("t1_s_read_cycles", 64'(cnt_hi), 64'd4);
        check("t1_m1_wait_cycles", 64'(cnt_wait_hi), 64'd3);
        check("t1_m0_wait_never", 64'(cnt_m0_wait), 64'd0);
        @(posedge clk); #1;
        drive_m(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

        // Test 2: simultaneous m0 read / m1 partial write right after reset.
        do_reset();
        sl_wait_n = 1;
        exp_q.push_back({1'b0, 1'b1, 32'h0000_4444});
        exp_q.push_back({1'b1, 1'b0, 32'h0});
        fork
            m_xfer(0, 1'b1, 32'h0000_0010, 4'hF, 32'h0);
            m_xfer(1, 1'b0, 32'h0000_0020, 4'b0011, 32'hAABB_CCDD);
        join
        exp_q.push_back({1'b1, 1'b1, 32'h1122_CCDD});
        m_xfer(1, 1'b1, 32'h0000_0020, 4'hF, 32'h0);

        // Test 3: continuous contention, zero-wait slave.
        do_reset();
        sl_wait_n = 0;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back({1'b0, 1'b1, 32'h0000_4444});
            exp_q.push_back({1'b1, 1'b1, 32'h1234_5678});
        end
        fork
            for (int k = 0; k < 3; k++) m_xfer(0, 1'b1, 32'h0000_0010, 4'hF, 32'h0);
            for (int k = 0; k < 3; k++) m_xfer(1, 1'b1, 32'hBFC0_0004, 4'hF, 32'h0);
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                check($sformatf("t3_s_read_cycle%0d", i), 64'(s_bus.read), 64'(i % 2));
            end
        join

        // Test 4: stuck slave trips the watchdog after 8 busy cycles.
        do_reset();
        sl_hang = 1'b1;
        drive_m(0, 1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'h0);
        cnt_hi = 0; seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (s_bus.read) begin
                cnt_hi++;
                seen = 1;
            end else if (seen) begin
                break;
            end
        end
        check("t4_busy_cycles", 64'(cnt_hi), 64'd8);
        check("t4_timeout_set", 64'(timeout), 64'd1);
        check("t4_state_idle", 64'(dbg_state), 64'(IDLE));
        drive_m(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        sl_hang = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back({1'b0, 1'b1, 32'h0000_4444});
        m_xfer(0, 1'b1, 32'h0000_0010, 4'hF, 32'h0);
        @(negedge clk);
        check("t4_timeout_sticky", 64'(timeout), 64'd1);

        // Test 5: reset in the second wait cycle of an m0 read.
        sl_wait_n = 3;
        @(posedge clk); #1;
        drive_m(0, 1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'h0);
        repeat (3) @(negedge clk);
        check("t5_busy_before_reset", 64'(s_bus.read), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t5_s_read_dropped", 64'(s_bus.read), 64'd0);
        check("t5_timeout_cleared", 64'(timeout), 64'd0);
        reset = 1'b0;
        drive_m(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(posedge clk); #1;
        exp_q.push_back({1'b0, 1'b1, 32'h0000_4444});
        exp_q.push_back({1'b1, 1'b1, 32'h1234_5678});
        fork
            m_xfer(0, 1'b1, 32'h0000_0010, 4'hF, 32'h0);
            m_xfer(1, 1'b1, 32'hBFC0_0004, 4'hF, 32'h0);
        join

        repeat (3) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
